gpio_input_irq: RTL

- Input-conditioning and interrupt stage that sits directly downstream of the GPIO pins.
- Samples the pad values (i_gpio is wired to the same gpio_pins net driven by the GPIO control block), then synchronizes them with 2 flops and debounces each bit with its own counter.
- Detects rising and falling edges on the debounced value, latches them into sticky W1C status bits, and raises a level interrupt to the CPU.
- Register access uses the same simple select/write-enable bus as the GPIO control block.

---
 rtl/gpio_input_irq.sv | 110 +++++++++++
 1 files changed

// File: rtl/gpio_input_irq.sv
// GPIO input conditioning: two-flop synchronizer and per-pin debounce.
// Also does edge detection into sticky W1C status and drives a level interrupt.
module gpio_input_irq #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int GPIO_WIDTH      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_sel,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic [GPIO_WIDTH-1:0] i_gpio,
    output logic [GPIO_WIDTH-1:0] o_level,
    output logic                  o_irq
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_RISE_EN = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FALL_EN = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(4'h8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LEVEL   = ADDR_WIDTH'(4'hC);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);

    logic [GPIO_WIDTH-1:0] sync1;
    logic [GPIO_WIDTH-1:0] sync2;
    logic [GPIO_WIDTH-1:0] stable;
    logic [GPIO_WIDTH-1:0] stable_nxt;
    logic [CNT_WIDTH-1:0]  cnt     [GPIO_WIDTH];
    logic [CNT_WIDTH-1:0]  cnt_nxt [GPIO_WIDTH];

    logic [GPIO_WIDTH-1:0] rise_en;
    logic [GPIO_WIDTH-1:0] fall_en;
    logic [GPIO_WIDTH-1:0] status;
    logic [GPIO_WIDTH-1:0] ev_set;
    logic [GPIO_WIDTH-1:0] w1c_clr;
    logic                  wr;
    logic                  unused_ok;

    assign wr        = i_sel & i_we;
    assign unused_ok = &{1'b0, i_wdata};

    always_comb begin
        for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
            stable_nxt[i] = stable[i];
            cnt_nxt[i]    = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Events are qualified by the enables as they stand on the accepting edge.
    assign ev_set  = (stable_nxt & ~stable & rise_en) | (~stable_nxt & stable & fall_en);
    assign w1c_clr = (wr && i_addr == ADDR_STATUS) ? i_wdata[GPIO_WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= i_gpio;
            sync2  <= sync1;
            stable <= stable_nxt;
            for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (wr && i_addr == ADDR_RISE_EN) begin
                rise_en <= i_wdata[GPIO_WIDTH-1:0];
            end
            if (wr && i_addr == ADDR_FALL_EN) begin
                fall_en <= i_wdata[GPIO_WIDTH-1:0];
            end
            // Set is OR-ed after the clear so a colliding event wins.
            status <= (status & ~w1c_clr) | ev_set;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_sel && !i_we) begin
            case (i_addr)
                ADDR_RISE_EN: o_rdata = DATA_WIDTH'(rise_en);
                ADDR_FALL_EN: o_rdata = DATA_WIDTH'(fall_en);
                ADDR_STATUS:  o_rdata = DATA_WIDTH'(status);
                ADDR_LEVEL:   o_rdata = DATA_WIDTH'(stable);
                default:      o_rdata = '0;
            endcase
        end
    end

    assign o_level = stable;
    assign o_irq   = |status;

endmodule
